daq_packet_rx: RTL and testbench
================================

Name: daq_packet_rx

Overview:
Host-side receiver and deframer for the byte stream emitted by daq_top (tx_data/tx_valid/tx_ready/tx_last).
- Hunts for the sync byte, then parses the header fields.
- Reassembles two-channel 16-bit samples and presents them on a valid/ready sample port.
- Checks length and checksum, and keeps saturating packet and error counters.
- Used on the capture/readback side and as a self-checking sink in system benches.

Packet format (fixed):
- SYNC
- timestamp[31:0] as 4 bytes, MSB first
- error_flags[15:0] as 2 bytes, MSB first
- N (sample count, 1 byte)
- N samples, 4 bytes each: ch0 hi, ch0 lo, ch1 hi, ch1 lo
- checksum: sum mod 256 of all preceding bytes, SYNC included
- s_last is high on the checksum byte only.

Parameters:
SYNC_BYTE, 8'hA5, header sync value
CNT_W, 16, width of saturating packet/error counters

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
s_data  in  8  stream byte (connects to tx_data)
s_valid  in  1  byte valid (tx_valid)
s_last  in  1  last byte of packet (tx_last)
s_ready  out  1  byte accepted when s_valid && s_ready (tx_ready)
hdr_valid  out  1  1-cycle pulse, header fields valid
hdr_timestamp  out  32  parsed timestamp
hdr_err_flags  out  16  parsed error flags
hdr_count  out  8  parsed sample count N
smp_ch0  out  16  sample channel 0
smp_ch1  out  16  sample channel 1
smp_valid  out  1  sample valid
smp_ready  in  1  sample consumer ready
pkt_done  out  1  1-cycle pulse at packet end (good or bad)
pkt_ok  out  1  qualifies pkt_done: 1 = length and checksum correct
csum_err  out  1  sticky; cleared by reset only
len_err  out  1  sticky; cleared by reset only
pkt_count  out  CNT_W  good packets, saturating
err_count  out  CNT_W  bad packets, saturating

Behaviour:
- Reset (async assert, any state incl. mid-packet):
  - state=IDLE; all outputs 0, except s_ready=1.
  - Partial packet discarded; counters and sticky flags cleared.
- Byte acceptance: s_ready = !(smp_valid && !smp_ready). Stalls only while a completed sample is unconsumed.
- States: IDLE, HDR, SAMP, CSUM, DRAIN.
- IDLE:
  - Accepted byte == SYNC_BYTE -> HDR; checksum accumulator := SYNC_BYTE.
  - Any other byte discarded, s_last ignored, no counters touched.
  - SYNC_BYTE arriving with s_last=1 is a length error (see "Early s_last").
- HDR: 7 bytes, byte index 0..6, shifted MSB-first into timestamp, then flags, then N.
  - hdr_valid pulses the cycle after byte 6 is accepted; hdr_* fields hold until the next header.
  - After byte 6: N==0 -> CSUM, else -> SAMP.
- SAMP: 4-byte sample assembly.
  - smp_valid rises the cycle after the 4th byte is accepted; it clears on smp_valid && smp_ready.
  - After sample N's 4th byte -> CSUM.
  - Sample index is 8-bit, byte index is 2-bit; no wrap beyond N.
- CSUM: accepted byte compared against the accumulator (8-bit wrap-around add over every accepted byte from SYNC on).
  - s_last=1 -> IDLE; pkt_done pulses the next cycle.
  - Match -> pkt_ok=1, pkt_count++.
  - Mismatch -> pkt_ok=0, csum_err=1, err_count++.
  - s_last=0 -> len_err=1, err_count++, pkt_done with pkt_ok=0, then DRAIN.
- Early s_last (on any byte in HDR or SAMP, or on SYNC in IDLE):
  - len_err=1, err_count++, pkt_done with pkt_ok=0, -> IDLE.
  - A partially assembled sample is not emitted. A sample already presented on smp_valid stays until consumed.
- DRAIN: discard bytes until one is accepted with s_last=1, then IDLE. No extra pkt_done.
- Counters saturate at all-ones; no wrap.
- If pkt_done and a new SYNC coincide: the SYNC is accepted in IDLE the cycle after the checksum byte, with no gap required.

Test Plan:
- Zero-sample packet: A5 12 34 56 78 AB CD 00 31 (last on 31) -> hdr_valid with ts=0x12345678, flags=0xABCD, N=0; pkt_done, pkt_ok=1, pkt_count=1.
- 4-sample packet with random samples, correct checksum, smp_ready=1 -> 4 smp_valid beats matching the sent ch0/ch1 words in order; pkt_ok=1.
- Same packet with smp_ready=0 for 10 cycles after the first sample -> s_ready low during the stall, no byte lost, all samples correct after release.
- Checksum byte corrupted (0x31 -> 0x32) -> pkt_done, pkt_ok=0, csum_err=1, err_count=1.
- Leading junk bytes 00 FF, then a valid packet -> junk ignored, packet parsed, pkt_ok=1. Separately, s_last on header byte 3 -> len_err=1, return to IDLE; the next good packet passes.
- rst asserted mid-SAMP -> all outputs and counters 0 immediately (async); the following good packet is received with pkt_count=1.

Source files
------------

// File: rtl/daq_packet_rx.sv
// daq_packet_rx
//   Receiver/deframer for the daq_top byte stream. Hunts for the sync byte,
//   parses timestamp / error flags / sample count, reassembles two-channel
//   16-bit samples, verifies length and checksum, and keeps saturating
//   good/bad packet counters plus sticky error flags.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready   byte stream input (valid/ready)
//   hdr_valid           1-cycle pulse when hdr_timestamp/err_flags/count update
//   smp_ch0/ch1/valid, smp_ready    sample output (valid/ready)
//   pkt_done, pkt_ok    end-of-packet pulse, qualified by pkt_ok
//   csum_err, len_err   sticky error flags
//   pkt_count, err_count  saturating good/bad packet counters
module daq_packet_rx #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic             hdr_valid,
    output logic [31:0]      hdr_timestamp,
    output logic [15:0]      hdr_err_flags,
    output logic [7:0]       hdr_count,
    output logic [15:0]      smp_ch0,
    output logic [15:0]      smp_ch1,
    output logic             smp_valid,
    input  logic             smp_ready,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic             csum_err,
    output logic             len_err,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SAMP,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t      r_state;
    logic [2:0]  r_hdr_idx;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_smp_idx;
    logic [7:0]  r_csum;
    logic [47:0] r_hdr_sh;
    logic [23:0] r_smp_sh;

    logic        w_accept;
    logic [7:0]  w_csum_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Only an unconsumed completed sample can hold off the byte stream.
    assign s_ready     = !(smp_valid && !smp_ready);
    assign w_accept    = s_valid && s_ready;
    assign w_csum_next = r_csum + s_data;

    // Data-only shift registers: they always hold the most recent accepted
    // bytes, so at header byte 6 they contain header bytes 0..5 and at sample
    // byte 3 they contain sample bytes 0..2. The accumulator is seeded with
    // SYNC_BYTE in IDLE; it only matters once a sync byte moves us to HDR.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_csum   <= (r_state == ST_IDLE) ? SYNC_BYTE : w_csum_next;
            r_hdr_sh <= {r_hdr_sh[39:0], s_data};
            r_smp_sh <= {r_smp_sh[15:0], s_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hdr_idx     <= '0;
            r_byte_idx    <= '0;
            r_smp_idx     <= '0;
            hdr_valid     <= 1'b0;
            hdr_timestamp <= '0;
            hdr_err_flags <= '0;
            hdr_count     <= '0;
            smp_ch0       <= '0;
            smp_ch1       <= '0;
            smp_valid     <= 1'b0;
            pkt_done      <= 1'b0;
            pkt_ok        <= 1'b0;
            csum_err      <= 1'b0;
            len_err       <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
        end else begin
            hdr_valid <= 1'b0;
            pkt_done  <= 1'b0;
            // A new sample completing in the same cycle overrides this clear.
            if (smp_valid && smp_ready)
                smp_valid <= 1'b0;

            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (s_data == SYNC_BYTE) begin
                            if (s_last) begin
                                len_err   <= 1'b1;
                                err_count <= sat_inc(err_count);
                                pkt_done  <= 1'b1;
                                pkt_ok    <= 1'b0;
                            end else begin
                                r_state   <= ST_HDR;
                                r_hdr_idx <= '0;
                            end
                        end
                    end

                    ST_HDR: begin
                        r_hdr_idx <= r_hdr_idx + 3'd1;
                        if (s_last) begin
                            len_err   <= 1'b1;
                            err_count <= sat_inc(err_count);
                            pkt_done  <= 1'b1;
                            pkt_ok    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else if (r_hdr_idx == 3'd6) begin
                            hdr_valid     <= 1'b1;
                            hdr_timestamp <= r_hdr_sh[47:16];
                            hdr_err_flags <= r_hdr_sh[15:0];
                            hdr_count     <= s_data;
                            r_smp_idx     <= '0;
                            r_byte_idx    <= '0;
                            r_state       <= (s_data == 8'd0) ? ST_CSUM : ST_SAMP;
                        end
                    end

                    ST_SAMP: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (s_last) begin
                            // Partially assembled sample is dropped.
                            len_err   <= 1'b1;
                            err_count <= sat_inc(err_count);
                            pkt_done  <= 1'b1;
                            pkt_ok    <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else if (r_byte_idx == 2'd3) begin
                            smp_ch0   <= r_smp_sh[23:8];
                            smp_ch1   <= {r_smp_sh[7:0], s_data};
                            smp_valid <= 1'b1;
                            r_smp_idx <= r_smp_idx + 8'd1;
                            if (r_smp_idx == hdr_count - 8'd1)
                                r_state <= ST_CSUM;
                        end
                    end

                    ST_CSUM: begin
                        pkt_done <= 1'b1;
                        if (s_last) begin
                            r_state <= ST_IDLE;
                            if (s_data == r_csum) begin
                                pkt_ok    <= 1'b1;
                                pkt_count <= sat_inc(pkt_count);
                            end else begin
                                pkt_ok    <= 1'b0;
                                csum_err  <= 1'b1;
                                err_count <= sat_inc(err_count);
                            end
                        end else begin
                            // Packet longer than announced: report once, then
                            // discard the rest of it.
                            pkt_ok    <= 1'b0;
                            len_err   <= 1'b1;
                            err_count <= sat_inc(err_count);
                            r_state   <= ST_DRAIN;
                        end
                    end

                    ST_DRAIN: begin
                        if (s_last)
                            r_state <= ST_IDLE;
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daq_packet_rx.sv
// Testbench for daq_packet_rx: table-driven packet records plus hand-written
// corner-case sequences; header, sample and end-of-packet expectations are
// queued when bytes are driven and popped as the DUT reports them.
module tb_daq_packet_rx;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic             hdr_valid;
    logic [31:0]      hdr_timestamp;
    logic [15:0]      hdr_err_flags;
    logic [7:0]       hdr_count;
    logic [15:0]      smp_ch0;
    logic [15:0]      smp_ch1;
    logic             smp_valid;
    logic             smp_ready;
    logic             pkt_done;
    logic             pkt_ok;
    logic             csum_err;
    logic             len_err;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    always #5 clk = ~clk;

    daq_packet_rx #(.SYNC_BYTE(8'hA5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .hdr_valid(hdr_valid), .hdr_timestamp(hdr_timestamp),
        .hdr_err_flags(hdr_err_flags), .hdr_count(hdr_count),
        .smp_ch0(smp_ch0), .smp_ch1(smp_ch1), .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok),
        .csum_err(csum_err), .len_err(len_err),
        .pkt_count(pkt_count), .err_count(err_count)
    );

    typedef struct { logic [31:0] ts; logic [15:0] fl; logic [7:0] n; } hdr_t;
    typedef struct { logic [15:0] c0; logic [15:0] c1; } smp_t;

    typedef struct {
        logic [31:0] ts;
        logic [15:0] fl;
        logic [7:0]  n;
        bit          bad_csum;
        bit          junk;
        bit          stall;
        logic [15:0] exp_pkt;
        logic [15:0] exp_err;
        bit          exp_cerr;
        bit          exp_lerr;
    } vec_t;

    hdr_t hdr_q[$];
    smp_t smp_q[$];
    bit   done_q[$];

    int total = 0;
    int bad   = 0;
    int stall_left = 0;
    bit stall_pending = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // One clock: wait for the falling edge, steer smp_ready, then observe
    // the DUT outputs produced by the preceding rising edge.
    task automatic tick();
        hdr_t h;
        smp_t s;
        bit   ok;
        @(negedge clk);
        if (stall_left > 0) begin
            smp_ready = 1'b0;
            stall_left--;
        end else begin
            smp_ready = 1'b1;
        end
        #1;
        if (!rst) begin
            if (smp_valid && !smp_ready) check("s_ready_stall", s_ready, 1'b0);
            if (!smp_valid)              check("s_ready_free", s_ready, 1'b1);
            if (hdr_valid) begin
                if (hdr_q.size() == 0) fail("hdr_unexpected");
                else begin
                    h = hdr_q.pop_front();
                    check("hdr_ts", hdr_timestamp, h.ts);
                    check("hdr_flags", hdr_err_flags, h.fl);
                    check("hdr_count", hdr_count, h.n);
                end
            end
            if (smp_valid && smp_ready) begin
                if (smp_q.size() == 0) fail("smp_unexpected");
                else begin
                    s = smp_q.pop_front();
                    check("smp_ch0", smp_ch0, s.c0);
                    check("smp_ch1", smp_ch1, s.c1);
                end
                if (stall_pending) begin
                    stall_left    = 10;
                    stall_pending = 0;
                end
            end
            if (pkt_done) begin
                if (done_q.size() == 0) fail("done_unexpected");
                else begin
                    ok = done_q.pop_front();
                    check("pkt_ok", pkt_ok, ok);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l);
        int guard;
        guard   = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        while (!s_ready) begin
            tick();
            guard++;
            if (guard > 100) begin
                fail("s_ready_timeout");
                break;
            end
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] ts, input logic [15:0] fl, input logic [7:0] n,
                            input bit bad_csum, input bit csum_last);
        logic [7:0] bq[$];
        logic [7:0] cs;
        hdr_t h;
        smp_t s;
        bq.push_back(8'hA5);
        bq.push_back(ts[31:24]); bq.push_back(ts[23:16]);
        bq.push_back(ts[15:8]);  bq.push_back(ts[7:0]);
        bq.push_back(fl[15:8]);  bq.push_back(fl[7:0]);
        bq.push_back(n);
        for (int k = 0; k < int'(n); k++) begin
            s.c0 = 16'($urandom());
            s.c1 = 16'($urandom());
            smp_q.push_back(s);
            bq.push_back(s.c0[15:8]); bq.push_back(s.c0[7:0]);
            bq.push_back(s.c1[15:8]); bq.push_back(s.c1[7:0]);
        end
        cs = 8'h00;
        foreach (bq[k]) cs = cs + bq[k];
        if (bad_csum) cs = cs + 8'h01;
        bq.push_back(cs);
        h.ts = ts; h.fl = fl; h.n = n;
        hdr_q.push_back(h);
        done_q.push_back(csum_last && !bad_csum);
        foreach (bq[k]) send_byte(bq[k], csum_last && (k == bq.size() - 1));
    endtask

    task automatic settle_and_check(input string tag, input logic [15:0] ep, input logic [15:0] ee,
                                    input bit ec, input bit el);
        repeat (3) tick();
        check({tag, "_pkt_count"}, pkt_count, ep);
        check({tag, "_err_count"}, err_count, ee);
        check({tag, "_csum_err"}, csum_err, ec);
        check({tag, "_len_err"}, len_err, el);
        check({tag, "_queues_empty"}, hdr_q.size() + smp_q.size() + done_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b1);
        check({tag, "_zero"}, {hdr_valid, hdr_timestamp, hdr_err_flags, hdr_count}, 64'd0);
        check({tag, "_smp_zero"}, {smp_ch0, smp_ch1, smp_valid}, 64'd0);
        check({tag, "_flags_zero"}, {pkt_done, pkt_ok, csum_err, len_err}, 64'd0);
        check({tag, "_cnt_zero"}, {pkt_count, err_count}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[5];
        logic [7:0] lit[9];

        vec[0] = '{32'h12345678, 16'hABCD, 8'd0, 0, 0, 0, 16'd1, 16'd0, 0, 0};
        vec[1] = '{32'hDEADBEEF, 16'h0001, 8'd4, 0, 0, 0, 16'd2, 16'd0, 0, 0};
        vec[2] = '{32'hDEADBEEF, 16'h0001, 8'd4, 0, 0, 1, 16'd3, 16'd0, 0, 0};
        vec[3] = '{32'h12345678, 16'hABCD, 8'd0, 1, 0, 0, 16'd3, 16'd1, 1, 0};
        vec[4] = '{32'h0A0B0C0D, 16'h8000, 8'd2, 0, 1, 0, 16'd4, 16'd1, 1, 0};

        lit[0] = 8'hA5; lit[1] = 8'h12; lit[2] = 8'h34; lit[3] = 8'h56; lit[4] = 8'h78;
        lit[5] = 8'hAB; lit[6] = 8'hCD; lit[7] = 8'h00; lit[8] = 8'h31;

        rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; smp_ready = 1'b1;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            if (vec[i].junk) begin
                send_byte(8'h00, 1'b0);
                send_byte(8'hFF, 1'b1);
            end
            if (vec[i].stall) stall_pending = 1'b1;
            send_pkt(vec[i].ts, vec[i].fl, vec[i].n, vec[i].bad_csum, 1'b1);
            settle_and_check($sformatf("vec%0d", i), vec[i].exp_pkt, vec[i].exp_err,
                             vec[i].exp_cerr, vec[i].exp_lerr);
        end

        // Literal zero-sample packet with hand-computed checksum 0x31.
        hdr_q.push_back('{32'h12345678, 16'hABCD, 8'd0});
        done_q.push_back(1'b1);
        for (int k = 0; k < 9; k++) send_byte(lit[k], k == 8);
        settle_and_check("literal", 16'd5, 16'd1, 1, 0);

        // s_last on header byte 3, then a good packet.
        done_q.push_back(1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        settle_and_check("early_last", 16'd5, 16'd2, 1, 1);
        send_pkt(32'h01020304, 16'h0F0F, 8'd1, 0, 1);
        settle_and_check("after_early", 16'd6, 16'd2, 1, 1);

        // Checksum byte without s_last: one bad pkt_done, then drain (a stray
        // sync inside the drain must not start a header).
        send_pkt(32'hCAFEF00D, 16'h1234, 8'd1, 0, 0);
        send_byte(8'h11, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h22, 1'b1);
        settle_and_check("drain", 16'd6, 16'd3, 1, 1);
        send_pkt(32'h55AA55AA, 16'h0000, 8'd3, 0, 1);
        settle_and_check("after_drain", 16'd7, 16'd3, 1, 1);

        // Sync byte carrying s_last in IDLE, then two back-to-back packets.
        done_q.push_back(1'b0);
        send_byte(8'hA5, 1'b1);
        send_pkt(32'h00000001, 16'h0002, 8'd2, 0, 1);
        send_pkt(32'hFFFFFFFF, 16'hFFFF, 8'd1, 0, 1);
        settle_and_check("sync_last_b2b", 16'd9, 16'd4, 1, 1);

        // Asynchronous reset in the middle of a sample.
        hdr_q.push_back('{32'h11223344, 16'h5566, 8'd3});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
        send_byte(8'h03, 1'b0);
        smp_q.push_back('{16'h789A, 16'hBCDE});
        send_byte(8'h78, 1'b0); send_byte(8'h9A, 1'b0);
        send_byte(8'hBC, 1'b0); send_byte(8'hDE, 1'b0);
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        rst = 1'b0;
        tick();
        send_pkt(32'h0BADBEEF, 16'h0042, 8'd2, 0, 1);
        settle_and_check("after_reset", 16'd1, 16'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
